// File: rtl/mips_pkg.sv
// Shared MIPS pipeline package.
// Holds the default geometry of the instruction side of the pipeline: program
// counter width, instruction width and instruction-memory depth. It also holds
// the primary opcode constants, the canonical NOP word, and the fetch-entry
// record that travels from fetch to decode.
package mips_pkg;

  localparam int PC_W       = 10;
  localparam int INSTR_W    = 32;
  localparam int IMEM_DEPTH = 1000;

  localparam logic [5:0] OP_RGRP = 6'b000001;
  localparam logic [5:0] OP_LW   = 6'b000010;
  localparam logic [5:0] OP_SW   = 6'b000011;

  localparam logic [INSTR_W-1:0] NOP = 32'h0400001F;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode handshake bundle.
//   if_valid : head entry present (driven by fetch)
//   if_ready : decode accepts the head this cycle (driven by decode)
//   if_instr : head instruction word
//   if_pc    : word address the head instruction was fetched from
// Modports: master = fetch side, slave = decode side.
interface fetch_unit_if import mips_pkg::*; #(
  parameter int PC_W    = mips_pkg::PC_W,
  parameter int INSTR_W = mips_pkg::INSTR_W
);

  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;

  modport master (output if_valid, if_instr, if_pc, input if_ready);
  modport slave  (input if_valid, if_instr, if_pc, output if_ready);

endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry synchronous skid FIFO holding fetch entries ({pc, instr}).
//   clk, rst  : clock, synchronous active-high reset (pointers/count only)
//   push      : write push_data at this edge
//   push_data : entry to store
//   pop       : discard the head at this edge (caller only pops when count != 0)
//   flush     : empty the FIFO at this edge; overrides push and pop
//   head      : oldest entry, all zeros while empty
//   count     : number of stored entries, 0..2
module fetch_skid_fifo #(
  parameter int ENTRY_W = 42
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [ENTRY_W-1:0] head,
  output logic [1:0]         count
);

  logic [ENTRY_W-1:0] mem_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // The fetch credit scheme must never push into a full FIFO unless the
      // head leaves in the same cycle.
      assert (!(push && !pop && (count_q == 2'd2)));
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  // Forcing zeros while empty keeps the decode-facing outputs at a known value
  // after reset and after a flush, without resetting the storage.
  assign head  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the MIPS pipeline.
// Owns the program counter and drives the synchronous instruction memory. It
// absorbs the memory's one-cycle read latency and hands {instr, pc} pairs to
// decode over a valid/ready handshake. Each issue is allowed only when the skid
// FIFO is guaranteed room for the word it returns, so a decode stall never
// drops or duplicates an instruction. A redirect from execute flushes the stage.
//   clk, rst    : single clock, synchronous active-high reset
//   imem_pc     : word address to instruction memory (always the current PC)
//   imem_instr  : memory word for the address sampled at the previous edge
//   redir_valid : taken branch/jump from execute
//   redir_pc    : redirect target (targets beyond the memory load 0)
//   fe          : fetch_unit_if.master towards decode
//   halted      : fetch stopped at end of memory
// Build option: define FETCH_HALT_EN to stop fetching after address
// IMEM_DEPTH-1. Without it the PC wraps to 0 and halted is tied low.
module fetch_unit import mips_pkg::*; #(
  parameter int PC_W       = mips_pkg::PC_W,
  parameter int INSTR_W    = mips_pkg::INSTR_W,
  parameter int IMEM_DEPTH = mips_pkg::IMEM_DEPTH,
  parameter int RESET_PC   = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redir_valid,
  input  logic [PC_W-1:0]    redir_pc,
  fetch_unit_if.master       fe,
  output logic               halted
);

  localparam int              ENTRY_W = PC_W + INSTR_W;
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(IMEM_DEPTH - 1);

  logic [PC_W-1:0]    pc_p0;
  logic               vld_p1;
  logic [PC_W-1:0]    pc_p1;
  logic [PC_W-1:0]    pc_nxt;
  logic [PC_W-1:0]    redir_tgt;
  logic               pop;
  logic               push;
  logic               issue;
  logic               halt_stop;
  logic [1:0]         fifo_cnt;
  logic [ENTRY_W-1:0] fifo_head;

`ifdef FETCH_HALT_EN
  logic halted_q;
  assign halted    = halted_q;
  assign halt_stop = halted_q;
`else
  assign halted    = 1'b0;
  assign halt_stop = 1'b0;
`endif

  assign pc_nxt    = (pc_p0 == LAST_PC) ? '0 : pc_p0 + 1'b1;
  assign redir_tgt = (32'(redir_pc) >= IMEM_DEPTH) ? '0 : redir_pc;

  assign pop  = fe.if_valid && fe.if_ready;
  assign push = vld_p1 && !redir_valid;

  // Credit rule: entries held + word in flight, less the one leaving now, must
  // stay below the FIFO depth so the word returned next cycle always fits.
  assign issue = !redir_valid && !halt_stop &&
                 (({1'b0, fifo_cnt} + {2'b0, vld_p1}) < (3'd2 + {2'b0, pop}));

  // ---- p0: PC / issue to instruction memory ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0  <= PC_W'(RESET_PC);
      vld_p1 <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_q <= 1'b0;
`endif
    end else if (redir_valid) begin
      pc_p0  <= redir_tgt;
      vld_p1 <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      vld_p1 <= issue;
      if (issue) begin
        pc_p0 <= pc_nxt;
`ifdef FETCH_HALT_EN
        if (pc_p0 == LAST_PC) halted_q <= 1'b1;
`endif
      end
    end
  end

  // ---- p1: memory read in flight, remember its address ----
  always_ff @(posedge clk) begin
    if (issue) pc_p1 <= pc_p0;
  end

  assign imem_pc = pc_p0;

  // ---- p2: returned word enters the skid FIFO ----
  fetch_skid_fifo #(
    .ENTRY_W (ENTRY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({pc_p1, imem_instr}),
    .pop       (pop),
    .flush     (redir_valid),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

  assign fe.if_valid = (fifo_cnt != 2'd0);
  assign fe.if_pc    = fifo_head[ENTRY_W-1 -: PC_W];
  assign fe.if_instr = fifo_head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural instruction memory whose word at
// address p is 32'hA5000000 | p, an in-order stream check on every accepted
// handshake, and cycle-exact checks around reset, stall, redirect and the end
// of memory. Define FETCH_HALT_EN for both bench and RTL to cover halting.
module tb_fetch_unit;
  import mips_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [PC_W-1:0]    imem_pc;
  logic [INSTR_W-1:0] imem_instr;
  logic               redir_valid;
  logic [PC_W-1:0]    redir_pc;
  logic               halted;

  int              nvec = 0;
  int              nmis = 0;
  logic [PC_W-1:0] exp_pc;

  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dec ();

  fetch_unit #(
    .PC_W       (PC_W),
    .INSTR_W    (INSTR_W),
    .IMEM_DEPTH (IMEM_DEPTH),
    .RESET_PC   (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_pc     (imem_pc),
    .imem_instr  (imem_instr),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .fe          (dec),
    .halted      (halted)
  );

  function automatic logic [31:0] word(input logic [PC_W-1:0] p);
    return 32'hA500_0000 | 32'(p);
  endfunction

  function automatic logic [PC_W-1:0] nxt(input logic [PC_W-1:0] p);
    return (32'(p) == IMEM_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) imem_instr <= word(imem_pc);

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with this cycle's inputs already set: checks the
  // handshake that completes at the coming edge, then advances one cycle.
  task automatic cyc();
    if (dec.if_valid === 1'b1 && dec.if_ready === 1'b1) begin
      chk_vec("stream_pc", 32'(dec.if_pc), 32'(exp_pc));
      chk_vec("stream_instr", dec.if_instr, word(exp_pc));
      exp_pc = nxt(exp_pc);
    end
    if (rst) exp_pc = '0;
    else if (redir_valid) exp_pc = (32'(redir_pc) >= IMEM_DEPTH) ? '0 : redir_pc;
    @(negedge clk);
  endtask

  initial begin
    redir_valid  = 1'b0;
    redir_pc     = '0;
    dec.if_ready = 1'b1;
    exp_pc       = '0;
    repeat (3) @(negedge clk);

    chk_vec("rst_valid", 32'(dec.if_valid), 32'd0);
    chk_vec("rst_instr", dec.if_instr, 32'd0);
    chk_vec("rst_pc", 32'(dec.if_pc), 32'd0);
    chk_vec("rst_halted", 32'(halted), 32'd0);
    chk_vec("rst_imem_pc", 32'(imem_pc), 32'd0);

    // cycle 0 issues address 0, word returns cycle 1, valid cycle 2
    rst = 1'b0;
    cyc();
    chk_vec("c1_valid", 32'(dec.if_valid), 32'd0);
    chk_vec("c1_imem_pc", 32'(imem_pc), 32'd1);
    cyc();
    chk_vec("c2_valid", 32'(dec.if_valid), 32'd1);
    chk_vec("c2_pc", 32'(dec.if_pc), 32'd0);
    chk_vec("c2_instr", dec.if_instr, 32'hA500_0000);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk_vec("run_valid", 32'(dec.if_valid), 32'd1);
      chk_vec("run_pc", 32'(dec.if_pc), 32'(i));
    end

    // stall in cycle 6: head pc 4, pc 5 returns into the FIFO, PC parks at 6
    dec.if_ready = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk_vec("stall_valid", 32'(dec.if_valid), 32'd1);
      chk_vec("stall_pc", 32'(dec.if_pc), 32'd4);
      chk_vec("stall_imem_pc", 32'(imem_pc), 32'd6);
      cyc();
    end
    dec.if_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_vec("resume_valid", 32'(dec.if_valid), 32'd1);
    end

    // redirect to 13 while decode stalls and a read is in flight
    dec.if_ready = 1'b0;
    redir_valid  = 1'b1;
    redir_pc     = 10'd13;
    cyc();
    redir_valid  = 1'b0;
    dec.if_ready = 1'b1;
    chk_vec("rd1_valid", 32'(dec.if_valid), 32'd0);
    chk_vec("rd1_imem_pc", 32'(imem_pc), 32'd13);
    cyc();
    chk_vec("rd2_valid", 32'(dec.if_valid), 32'd0);
    cyc();
    chk_vec("rd3_valid", 32'(dec.if_valid), 32'd1);
    chk_vec("rd3_pc", 32'(dec.if_pc), 32'd13);
    for (int i = 0; i < 3; i++) cyc();

    // fill the FIFO, then redirect out of range while the head is accepted
    dec.if_ready = 1'b0;
    cyc();
    dec.if_ready = 1'b1;
    redir_valid  = 1'b1;
    redir_pc     = 10'd1020;
    cyc();
    redir_valid  = 1'b0;
    chk_vec("rf1_valid", 32'(dec.if_valid), 32'd0);
    chk_vec("rf1_imem_pc", 32'(imem_pc), 32'd0);
    cyc();
    chk_vec("rf2_valid", 32'(dec.if_valid), 32'd0);
    cyc();
    chk_vec("rf3_valid", 32'(dec.if_valid), 32'd1);
    chk_vec("rf3_pc", 32'(dec.if_pc), 32'd0);
    for (int i = 0; i < 2; i++) cyc();

    // end of memory
    redir_valid = 1'b1;
    redir_pc    = 10'd997;
    cyc();
    redir_valid = 1'b0;
    cyc();
    cyc();
    chk_vec("eom_pc997", 32'(dec.if_pc), 32'd997);
    cyc();
    chk_vec("eom_pc998", 32'(dec.if_pc), 32'd998);
`ifdef FETCH_HALT_EN
    chk_vec("eom_halt_set", 32'(halted), 32'd1);
`else
    chk_vec("eom_halt_off", 32'(halted), 32'd0);
`endif
    cyc();
    chk_vec("eom_pc999", 32'(dec.if_pc), 32'd999);
    cyc();
`ifdef FETCH_HALT_EN
    chk_vec("halt_valid", 32'(dec.if_valid), 32'd0);
    chk_vec("halt_hold", 32'(halted), 32'd1);
    cyc();
    chk_vec("halt_valid2", 32'(dec.if_valid), 32'd0);
    chk_vec("halt_hold2", 32'(halted), 32'd1);
    redir_valid = 1'b1;
    redir_pc    = 10'd0;
    cyc();
    redir_valid = 1'b0;
    chk_vec("halt_clear", 32'(halted), 32'd0);
    cyc();
    cyc();
    chk_vec("restart_valid", 32'(dec.if_valid), 32'd1);
    chk_vec("restart_pc", 32'(dec.if_pc), 32'd0);
`else
    chk_vec("wrap_valid", 32'(dec.if_valid), 32'd1);
    chk_vec("wrap_pc", 32'(dec.if_pc), 32'd0);
    chk_vec("wrap_halted", 32'(halted), 32'd0);
`endif
    for (int i = 0; i < 3; i++) cyc();

    // reset mid-stream with the FIFO full and a redirect pending
    dec.if_ready = 1'b0;
    cyc();
    rst          = 1'b1;
    redir_valid  = 1'b1;
    redir_pc     = 10'd5;
    dec.if_ready = 1'b1;
    cyc();
    redir_valid  = 1'b0;
    chk_vec("mrst_valid", 32'(dec.if_valid), 32'd0);
    chk_vec("mrst_instr", dec.if_instr, 32'd0);
    chk_vec("mrst_pc", 32'(dec.if_pc), 32'd0);
    chk_vec("mrst_halted", 32'(halted), 32'd0);
    chk_vec("mrst_imem_pc", 32'(imem_pc), 32'd0);
    rst = 1'b0;
    cyc();
    chk_vec("mrst_c1_valid", 32'(dec.if_valid), 32'd0);
    cyc();
    chk_vec("mrst_c2_valid", 32'(dec.if_valid), 32'd1);
    chk_vec("mrst_c2_pc", 32'(dec.if_pc), 32'd0);
    chk_vec("mrst_c2_instr", dec.if_instr, 32'hA500_0000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_vec("mrst_run_valid", 32'(dec.if_valid), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS pipeline: owns the program counter, drives the word address into the synchronous instruction memory, absorbs that memory's one-cycle read latency, and delivers {instruction, pc} pairs to decode over a valid/ready handshake. A 2-entry skid FIFO plus credit counting keeps the in-flight read from being lost when decode stalls. Branch/jump redirects flush the stage.

## Interface
- `PC_W`, 10, word-address width (matches instruction memory `pc` port)
- `INSTR_W`, 32, instruction width
- `IMEM_DEPTH`, 1000, number of valid instruction words (addresses 0..IMEM_DEPTH-1)
- `RESET_PC`, 0, first fetch address after reset
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_pc`  out  PC_W  address to instruction memory; sampled by memory on every rising edge
- `imem_instr`  in  INSTR_W  memory output; holds word for the address sampled at the previous edge
- `redir_valid`  in  1  redirect request from execute (taken branch/jump)
- `redir_pc`  in  PC_W  redirect target word address
- `if_valid`  out  1  FIFO head valid
- `if_ready`  in  1  decode accepts head this cycle
- `if_instr`  out  INSTR_W  head instruction
- `if_pc`  out  PC_W  address the head instruction came from
- `halted`  out  1  fetch stopped at end of memory (see Configuration)

## Operation
- State: `pc_q`, `inflight` (1 bit + its pc), FIFO (2 entries, count 0..2), `halted_q`.
- Issue: `imem_pc = pc_q` always. A cycle is an issue cycle when not in reset, no redirect, not halted, and `count + inflight - pop < 2` (pop = `if_valid && if_ready`). Issue sets `inflight`, records `pc_q`, advances `pc_q`.
- PC advance: `pc_q + 1`; from `IMEM_DEPTH-1` wraps to 0 (macro off).
- Return: when `inflight` is set, `imem_instr` is pushed with its recorded pc at that edge. Credit rule guarantees space; push to full FIFO is an assertion failure.
- Pop and push same cycle: count unchanged, order preserved.
- Redirect (highest priority after `rst`): the pop handshake in that cycle still completes; then FIFO emptied, `inflight` discarded (word not pushed), `pc_q <= redir_pc`, `halted_q` cleared, no issue that cycle. `redir_pc >= IMEM_DEPTH` loads 0.
- Decode must hold `if_ready` independent of `if_valid`; outputs are stable while `if_valid && !if_ready`.

## Timing
- Reset values: `pc_q = RESET_PC`, `imem_pc = RESET_PC`, `if_valid = 0`, `if_instr = 0`, `if_pc = 0`, `halted = 0`, count 0, `inflight = 0`.
- First cycle with `rst` low = cycle 0: issue `RESET_PC`; word returns cycle 1; `if_valid` high cycle 2.
- Redirect in cycle n: target issued n+1, `if_valid` for target in n+3.
- Steady state with `if_ready` held high: one instruction per cycle (count 1, inflight 1).
- `if_ready` low: at most two issues complete before issue stops; no word dropped or duplicated. Throughput resumes the cycle after `if_ready` returns.
- `rst` mid-operation: all state reset at that edge regardless of redirect/handshake; in-flight data discarded.

## Configuration
- `FETCH_HALT_EN` defined: after issuing address `IMEM_DEPTH-1`, `halted_q` sets, issue stops, FIFO drains normally; `halted` stays 1 until redirect or `rst`.
- Undefined: PC wraps to 0, `halted` tied 0.

## Structure
- Shared package `mips_pkg`: `PC_W`, `INSTR_W`, `IMEM_DEPTH`, opcode constants (R-group 6'b000001, LW 6'b000010, SW 6'b000011), `NOP` word 32'h0400001F, fetch-entry struct {pc, instr}.
- Sub-module `fetch_skid_fifo`: 2-entry synchronous FIFO of fetch entries with push/pop/flush/count; all PC and credit logic stays in `fetch_unit`.

## Test plan
- Reset release, `if_ready` high, memory 0..3 preloaded -> `if_valid` rises cycle 2, `if_pc` 0,1,2,3 on consecutive cycles with matching words.
- `if_ready` low cycles 4–8 -> FIFO holds 2 entries, `imem_pc` frozen, on release stream continues with no gap/duplicate in `if_pc`.
- `redir_valid` with `redir_pc=13` while FIFO full and read in flight -> no pre-redirect word appears after redirect; first `if_pc=13` three cycles later.
- Redirect and accepting handshake in same cycle -> the accepted word counts once; subsequent stream starts at target.
- Run from pc 997, macro off -> `if_pc` 997,998,999,0; macro on -> 997,998,999, then `halted=1`, `if_valid` drops, redirect to 0 clears `halted`.
- `rst` asserted mid-stream with stall -> next cycle all outputs at reset values; restart from `RESET_PC` per cycle-2 rule.
